// File: rtl/tennis_pkg.sv
// Shared types and constants for the rally controller and its helpers.
package tennis_pkg;

  localparam int unsigned POS_W = 4;
  localparam int unsigned LED_W = 16;

  // Match sequencing states
  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    FLIGHT    = 2'd1,
    POINT     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  // Court ends
  localparam logic [POS_W-1:0] POS_P0 = 4'd0;
  localparam logic [POS_W-1:0] POS_P1 = 4'd15;

  // LED patterns for a scored point and for the finished match
  localparam logic [LED_W-1:0] LED_P0_HALF = 16'h00FF;
  localparam logic [LED_W-1:0] LED_P1_HALF = 16'hFF00;
  localparam logic [LED_W-1:0] LED_ALL     = 16'hFFFF;

  // One-hot LED for a ball position
  function automatic logic [LED_W-1:0] pos_to_lights(input logic [POS_W-1:0] pos);
    return LED_W'(1) << pos;
  endfunction

  // Where the ball waits before a serve; squash always serves from the front
  function automatic logic [POS_W-1:0] park_pos(input logic server, input logic squash_mode);
    return (squash_mode || !server) ? POS_P0 : POS_P1;
  endfunction

endpackage

// File: rtl/hit_edge_detect.sv
// Registered rising-edge detector for synchronized button levels.
// Ports: clk, rst (async active-low), level (button levels), rise (one-cycle
// pulse per bit, one cycle after the level rises).
module hit_edge_detect #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] level_q;

  // Previous level and registered edge pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      rise    <= '0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/rally_controller.sv
// Sequences one tennis/squash match on a 16-LED court: serve, ball flight on
// tick pulses, hit/miss/early-swing judging, scoring and rally speed level.
// Ports: clk, rst (async active-low), tick (ball step), squash (mode),
// hits (button levels); outputs ball_pos, ball_dir, lights, score0, score1,
// speed_level, game_over, winner -- all registered.
module rally_controller
  import tennis_pkg::*;
#(
  parameter int unsigned WIN_SCORE  = 7,
  parameter int unsigned POINT_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        squash,
  input  logic [1:0]  hits,
  output logic [3:0]  ball_pos,
  output logic        ball_dir,
  output logic [15:0] lights,
  output logic [3:0]  score0,
  output logic [3:0]  score1,
  output logic [2:0]  speed_level,
  output logic        game_over,
  output logic        winner
);

  localparam int unsigned HOLD_W = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;

  state_t            state_q, state_d;
  logic              server_q, server_d;
  logic              turn_q, turn_d;
  logic              squash_q, squash_d;
  logic              scorer_q, scorer_d;
  logic [1:0]        ret_cnt_q, ret_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [3:0]  pos_d;
  logic        dir_d;
  logic [15:0] lights_d;
  logic [3:0]  score0_d, score1_d;
  logic [2:0]  speed_d;
  logic        game_over_d, winner_d;

  logic [1:0]  hit_rise;
  logic        recv_valid;
  logic        receiver;
  logic [3:0]  recv_end;
  logic        recv_hit;
  logic        at_recv_end;
  logic        award;
  logic        award_to;
  logic [3:0]  scorer_score;

  hit_edge_detect #(.WIDTH(2)) u_hit_edge (
    .clk   (clk),
    .rst   (rst),
    .level (hits),
    .rise  (hit_rise)
  );

  // Who may hit now and where they must be; squash only receives on the way back
  always_comb begin
    recv_valid = 1'b1;
    receiver   = ball_dir;
    recv_end   = ball_dir ? POS_P1 : POS_P0;
    if (squash_q) begin
      recv_valid = ~ball_dir;
      receiver   = turn_q;
      recv_end   = POS_P0;
    end
  end

  assign recv_hit     = recv_valid & hit_rise[receiver];
  assign at_recv_end  = (ball_pos == recv_end);
  assign scorer_score = scorer_q ? score1 : score0;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    server_d    = server_q;
    turn_d      = turn_q;
    squash_d    = squash_q;
    scorer_d    = scorer_q;
    ret_cnt_d   = ret_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    pos_d       = ball_pos;
    dir_d       = ball_dir;
    lights_d    = lights;
    score0_d    = score0;
    score1_d    = score1;
    speed_d     = speed_level;
    game_over_d = game_over;
    winner_d    = winner;
    award       = 1'b0;
    award_to    = 1'b0;

    unique case (state_q)
      SERVE: begin
        squash_d = squash;
        pos_d    = park_pos(server_q, squash);
        dir_d    = (pos_d == POS_P0);
        lights_d = pos_to_lights(pos_d);
        if (hit_rise[server_q]) begin
          state_d = FLIGHT;
          turn_d  = server_q;
        end
      end

      FLIGHT: begin
        if (recv_hit && at_recv_end) begin
          // Return beats a same-cycle tick: the ball turns without moving
          dir_d     = ~ball_dir;
          ret_cnt_d = ret_cnt_q + 2'd1;
          if (ret_cnt_q == 2'd3 && speed_level != 3'd7)
            speed_d = speed_level + 3'd1;
          if (squash_q)
            turn_d = ~turn_q;
        end else if (recv_hit) begin
          award    = 1'b1;
          award_to = ~receiver;
        end else if (tick) begin
          if (recv_valid && at_recv_end) begin
            award    = 1'b1;
            award_to = ~receiver;
          end else begin
            pos_d    = ball_dir ? ball_pos + 4'd1 : ball_pos - 4'd1;
            lights_d = pos_to_lights(pos_d);
            // Squash front wall bounces the ball on arrival
            if (squash_q && ball_dir && pos_d == POS_P1)
              dir_d = 1'b0;
          end
        end
      end

      POINT: begin
        if (tick) begin
          if (hold_cnt_q == HOLD_W'(POINT_HOLD - 1)) begin
            if (scorer_score == 4'(WIN_SCORE)) begin
              state_d     = GAME_OVER;
              game_over_d = 1'b1;
              winner_d    = scorer_q;
              lights_d    = LED_ALL;
            end else begin
              state_d   = SERVE;
              server_d  = scorer_q;
              speed_d   = 3'd0;
              ret_cnt_d = 2'd0;
              pos_d     = park_pos(scorer_q, squash);
              dir_d     = (pos_d == POS_P0);
              lights_d  = pos_to_lights(pos_d);
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end

      GAME_OVER: begin
        lights_d = LED_ALL;
      end

      default: state_d = SERVE;
    endcase

    // Point award: score on entry to POINT, saturating at the match target
    if (award) begin
      state_d    = POINT;
      scorer_d   = award_to;
      hold_cnt_d = '0;
      if (award_to) begin
        lights_d = LED_P1_HALF;
        if (score1 < 4'(WIN_SCORE)) score1_d = score1 + 4'd1;
      end else begin
        lights_d = LED_P0_HALF;
        if (score0 < 4'(WIN_SCORE)) score0_d = score0 + 4'd1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SERVE;
      server_q    <= 1'b0;
      turn_q      <= 1'b0;
      squash_q    <= 1'b0;
      scorer_q    <= 1'b0;
      ret_cnt_q   <= 2'd0;
      hold_cnt_q  <= '0;
      ball_pos    <= POS_P0;
      ball_dir    <= 1'b1;
      lights      <= 16'h0001;
      score0      <= 4'd0;
      score1      <= 4'd0;
      speed_level <= 3'd0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      state_q     <= state_d;
      server_q    <= server_d;
      turn_q      <= turn_d;
      squash_q    <= squash_d;
      scorer_q    <= scorer_d;
      ret_cnt_q   <= ret_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      ball_pos    <= pos_d;
      ball_dir    <= dir_d;
      lights      <= lights_d;
      score0      <= score0_d;
      score1      <= score1_d;
      speed_level <= speed_d;
      game_over   <= game_over_d;
      winner      <= winner_d;
    end
  end

endmodule

// File: doc/rally_controller.md
# rally_controller

Sequences one tennis/squash match on the 16-LED court. Runs on the system clock and advances the ball on one-cycle `tick` pulses from the ball-speed clock divider. Judges hits, misses and early swings, keeps the score and raises the rally speed level fed back to the divider. Drives the LED bar and the per-player scores consumed by the seven-segment display block.

## Interface
Parameters:
- `WIN_SCORE`, 7: points needed to win the match; legal range 1..15.
- `POINT_HOLD`, 4: ticks the POINT display is held before the next serve; must be ≥1.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `tick`, in, 1: one-`clk` pulse, one ball step.
- `squash`, in, 1: 1 = squash mode, 0 = tennis mode. Already synchronized.
- `hits`, in, 2: player button levels, already synchronized; bit0 = player 0, bit1 = player 1.
- `ball_pos`, out, 4: ball position, 0..15.
- `ball_dir`, out, 1: 1 = increasing position.
- `lights`, out, 16: LED bar.
- `score0`, `score1`, out, 4 each: player scores.
- `speed_level`, out, 3: rally speed level to the clock divider.
- `game_over`, out, 1: match finished.
- `winner`, out, 1: valid only while `game_over` = 1.

## Operation
Reset values:
- State SERVE, server = 0.
- `ball_pos` = 0, `ball_dir` = 1, `lights` = 16'h0001.
- `score0` = `score1` = 0, `speed_level` = 0.
- `game_over` = 0, `winner` = 0.

Hit events:
- Only rising edges of `hits` count; held buttons never retrigger.

Ends and receiver:
- Tennis: player 0 owns position 0, player 1 owns position 15.
- Squash: both players hit at position 0, and position 15 is a wall.
- Tennis receiver: the player the ball is moving toward.
- Squash receiver: the player whose turn it is, and only while `ball_dir` = 0.

States:
- **SERVE**:
  - Ball parks at the server's end; in squash the ball always parks at 0.
  - `squash` is sampled here and held for the whole point.
  - A hit event from the server sets the direction away from that end and moves to FLIGHT.
  - Ticks and all other hits are ignored.
- **FLIGHT**:
  - Each tick moves the ball ±1.
  - Squash wall: on arrival at 15, `ball_dir` flips on the same edge, so the next tick moves the ball to 14.
  - Return: a receiver hit event while the ball is at the receiver's end flips `ball_dir`, counts a return and hands the turn over (squash: the turn toggles).
  - Early swing: a receiver hit event while the ball is not at the receiver's end awards the point to the opponent.
  - Miss: a tick while the ball sits at the receiver's end with no return awards the point to the opponent.
  - Hits from the non-receiver are always ignored.
  - When a return and a tick land in the same cycle, the return wins and the ball does not move that cycle.
  - `speed_level` increments after every 4th return and saturates at 7.
- **POINT**:
  - The scorer's score increments on entry. Scores saturate at `WIN_SCORE`.
  - `lights` shows the scorer's half: 16'h00FF for player 0, 16'hFF00 for player 1.
  - Stays for `POINT_HOLD` ticks.
  - Exit: if the score now equals `WIN_SCORE`, go to GAME_OVER; otherwise go to SERVE with server = scorer, and clear `speed_level` and the return count.
- **GAME_OVER**:
  - `game_over` = 1, `winner` = scorer.
  - `lights` = 16'hFFFF.
  - Leaves only on reset.

Lights:
- `lights` is 1 << `ball_pos` outside POINT and GAME_OVER.

## Timing
- All outputs are registered.
- Hit-edge detection adds 1 cycle: a button rising in cycle n is acted on at the edge ending cycle n+1.
- A `tick` in cycle n updates `ball_pos`/`lights` at the edge ending cycle n.
- Score increment occurs at the edge entering POINT.
- `game_over` asserts at the edge leaving POINT.
- `tick` may arrive at any rate, including every cycle. No handshake is required.
- Reset is honored mid-rally: all outputs return to their reset values asynchronously.

## Structure
- A shared package, `tennis_pkg`, holds:
  - the state enum (SERVE, FLIGHT, POINT, GAME_OVER);
  - position constants `POS_P0` = 0 and `POS_P1` = 15;
  - the LED patterns for each half and for all-on.
- A sub-module, `hit_edge_detect`, is instantiated once at width 2. It takes `clk`/`rst` and outputs a per-bit rising-edge pulse.
- The rest is a single FSM plus counters: return count, hold count, and scores.

## Test plan
- Reset, then player-0 press, then 15 ticks → `ball_pos` steps 1..15 with `lights` = 1 << pos; a player-1 press at pos 15 flips `ball_dir` to 0.
- Tennis: after the serve, 16 ticks with no player-1 press → miss; `score0` = 1, `lights` = 16'h00FF for 4 ticks, then SERVE with server 0 at pos 0.
- Early swing: a player-1 press at pos 10 while inbound → `score0` increments, and `ball_pos` does not advance on later ticks.
- Eight clean returns → `speed_level` reads 1 after return 4 and 2 after return 8; it clears to 0 in the next SERVE.
- Squash: ball reflects at 15 with no press; a player-1 press at pos 0 is ignored on turn 0; the player-0 return toggles the turn; held buttons never retrigger.
- Player 1 wins 7 points → `game_over` = 1, `winner` = 1, `lights` = 16'hFFFF, and ticks/hits have no effect. Reset asserted mid-rally clears everything immediately.
